// File: rtl/minisys_bus_pkg.sv
// minisys_bus_pkg
//   Shared definitions for the Minisys-1 bus controller:
//   - bus_state_t    : controller FSM states
//   - DEFAULT_IO_BASE: addr[31:10] value that selects the IO window
//   - CH_*           : channel indices of the standard Minisys peripherals
package minisys_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } bus_state_t;

  localparam logic [21:0] DEFAULT_IO_BASE = 22'h3fffff;

  localparam int CH_DISP   = 0;
  localparam int CH_KB     = 1;
  localparam int CH_TIMER  = 2;
  localparam int CH_PWM    = 3;
  localparam int CH_COP    = 5;
  localparam int CH_LED    = 6;
  localparam int CH_SWITCH = 7;

endpackage

// File: rtl/io_timeout_ctr.sv
// io_timeout_ctr
//   Counts ACCESS cycles of an IO transaction and flags when the selected
//   peripheral has had TIMEOUT cycles to respond without acknowledging.
//   Only built into io_bus_ctrl when IO_TIMEOUT_EN is defined.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   clear    : restart the count (asserted on the cycle before ACCESS)
//   enable   : high while the controller is in ACCESS
//   ack      : selected channel's ack; an ack always beats expiry
//   expired  : combinational, high in the last permitted ACCESS cycle
//              when no ack is present
module io_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic ack,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // The count equals the number of completed ACCESS cycles, so the
  // TIMEOUT-th cycle is the one where cnt == TIMEOUT-1.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && !ack) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = enable && !ack && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl
//   Minisys-1 bus controller. Memory accesses pass straight through to the
//   data memory; accesses whose addr[31:10] equals IO_BASE go to one of
//   N_CH peripherals (channel = addr[9:4]) through a registered handshake
//   that stalls the CPU until the peripheral acknowledges. Unmapped
//   channels (and, with IO_TIMEOUT_EN, silent peripherals) give a
//   one-cycle bus-error pulse and read data of zero.
// Configuration macro:
//   IO_TIMEOUT_EN : compile in the ACCESS timeout (TIMEOUT cycles). When
//                   undefined ACCESS waits for ack indefinitely.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cpu_r, cpu_w, cpu_addr,
//   cpu_wdata                : CPU request (write wins if both strobes set)
//   cpu_rdata, cpu_stall,
//   cpu_buserr               : CPU response
//   mem_r, mem_w, mem_rdata  : data-memory side (combinational)
//   io_sel, io_r, io_w,
//   io_addr, io_wdata        : registered peripheral request
//   io_rdata, io_ack         : per-channel peripheral response
module io_bus_ctrl
  import minisys_bus_pkg::*;
#(
  parameter int          N_CH    = 8,
  parameter logic [21:0] IO_BASE = DEFAULT_IO_BASE,
  parameter int          IO_DW   = 16,
  parameter int          TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_r,
  input  logic                   cpu_w,
  input  logic [31:0]            cpu_addr,
  input  logic [31:0]            cpu_wdata,
  output logic [31:0]            cpu_rdata,
  output logic                   cpu_stall,
  output logic                   cpu_buserr,
  output logic                   mem_r,
  output logic                   mem_w,
  input  logic [31:0]            mem_rdata,
  output logic [N_CH-1:0]        io_sel,
  output logic                   io_r,
  output logic                   io_w,
  output logic [3:0]             io_addr,
  output logic [IO_DW-1:0]       io_wdata,
  input  logic [N_CH*IO_DW-1:0]  io_rdata,
  input  logic [N_CH-1:0]        io_ack
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  if (N_CH < 1 || N_CH > 64 || IO_DW < 1 || IO_DW > 32 || TIMEOUT < 1) begin : g_bad_params
    $error("io_bus_ctrl: parameter out of range");
  end

  bus_state_t state, next_state;

  logic [CH_W-1:0]  ch_q;
  logic [N_CH-1:0]  io_sel_q;
  logic             io_r_q, io_w_q;
  logic [3:0]       io_addr_q;
  logic [IO_DW-1:0] io_wdata_q;
  logic [31:0]      rdata_q;
  logic             err_q;

  logic             req, is_io, mapped, start;
  logic             sel_ack, expired;
  logic [IO_DW-1:0] sel_rdata;
  logic [31:0]      cpu_rdata_c;
  logic             cpu_stall_c, cpu_buserr_c, mem_r_c, mem_w_c;

  // Only the low IO_DW bits of store data reach the peripherals.
  logic unused_wdata;
  assign unused_wdata = ^cpu_wdata;

  assign req    = cpu_r | cpu_w;
  assign is_io  = (cpu_addr[31:10] == IO_BASE);
  assign mapped = ({1'b0, cpu_addr[9:4]} < 7'(N_CH));

  // Pick out the latched channel's ack and data; acks from any other
  // channel never reach the FSM.
  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch_q == CH_W'(k)) begin
        sel_ack   = io_ack[k];
        sel_rdata = io_rdata[k*IO_DW +: IO_DW];
      end
    end
  end

`ifdef IO_TIMEOUT_EN
  io_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (start),
    .enable  (state == ACCESS),
    .ack     (sel_ack),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and CPU/memory-side outputs. In IDLE the stall comes
  // straight from the request so the CPU freezes in the cycle it asks;
  // memory traffic never leaves IDLE.
  always_comb begin
    next_state   = state;
    start        = 1'b0;
    cpu_stall_c  = 1'b0;
    cpu_buserr_c = 1'b0;
    cpu_rdata_c  = 32'h0;
    mem_r_c      = 1'b0;
    mem_w_c      = 1'b0;
    case (state)
      IDLE: begin
        if (req && is_io) begin
          cpu_stall_c = 1'b1;
          start       = 1'b1;
          next_state  = mapped ? ACCESS : DONE;
        end else if (req) begin
          mem_w_c     = cpu_w;
          mem_r_c     = cpu_r & ~cpu_w;
          cpu_rdata_c = mem_rdata;
        end
      end
      ACCESS: begin
        cpu_stall_c = 1'b1;
        if (sel_ack || expired) begin
          next_state = DONE;
        end
      end
      DONE: begin
        cpu_rdata_c  = rdata_q;
        cpu_buserr_c = err_q;
        next_state   = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Latched transaction: captured on the IDLE cycle of an IO request,
  // strobes dropped when ACCESS finishes. Read data starts at zero so
  // writes and errored reads return zero in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q       <= '0;
      io_sel_q   <= '0;
      io_r_q     <= 1'b0;
      io_w_q     <= 1'b0;
      io_addr_q  <= 4'h0;
      io_wdata_q <= '0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else if (start) begin
      ch_q       <= cpu_addr[4 +: CH_W];
      io_addr_q  <= cpu_addr[3:0];
      io_wdata_q <= cpu_wdata[IO_DW-1:0];
      rdata_q    <= 32'h0;
      err_q      <= !mapped;
      if (mapped) begin
        io_sel_q <= N_CH'(1) << cpu_addr[9:4];
        io_r_q   <= ~cpu_w;
        io_w_q   <= cpu_w;
      end
    end else if (state == ACCESS && (sel_ack || expired)) begin
      io_sel_q <= '0;
      io_r_q   <= 1'b0;
      io_w_q   <= 1'b0;
      if (sel_ack && !io_w_q) begin
        rdata_q <= 32'(sel_rdata);
      end
      if (!sel_ack) begin
        err_q <= 1'b1;
      end
    end
  end

  // Everything is held at zero while reset is high, including the
  // combinational memory path.
  always_comb begin
    cpu_rdata  = rst ? 32'h0 : cpu_rdata_c;
    cpu_stall  = rst ? 1'b0  : cpu_stall_c;
    cpu_buserr = rst ? 1'b0  : cpu_buserr_c;
    mem_r      = rst ? 1'b0  : mem_r_c;
    mem_w      = rst ? 1'b0  : mem_w_c;
    io_sel     = rst ? '0    : io_sel_q;
    io_r       = rst ? 1'b0  : io_r_q;
    io_w       = rst ? 1'b0  : io_w_q;
    io_addr    = rst ? 4'h0  : io_addr_q;
    io_wdata   = rst ? '0    : io_wdata_q;
  end

endmodule
